// File: rtl/tone_sequencer_if.sv
// Control/table-write/divider-drive bundle between the upstream control, the sequencer and the divider.
// The slave modport is the sequencer side; the master modport is the controller/bench side.
interface tone_sequencer_if #(
    parameter int DIV_W = 32,
    parameter int DUR_W = 32,
    parameter int IDX_W = 3
);
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [DUR_W-1:0] step_dur;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [DIV_W-1:0] wr_data;
    logic [DIV_W-1:0] divisor;
    logic             div_reset_n;
    logic [IDX_W-1:0] step_idx;
    logic             step_tick;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, loop_en, step_dur, wr_en, wr_addr, wr_data,
        input  divisor, div_reset_n, step_idx, step_tick, busy, done
    );

    modport slave (
        input  start, stop, loop_en, step_dur, wr_en, wr_addr, wr_data,
        output divisor, div_reset_n, step_idx, step_tick, busy, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// Steps the divider through a divisor table, each step = 1 LOAD + step_dur RUN cycles; all outputs registered.
// No backpressure: start is a level sampled only in IDLE, stop aborts LOAD/RUN on the next edge.
module tone_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int DIV_W     = 32,
    parameter int DUR_W     = 32,
    parameter int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic               inclk,
    input  logic               reset,
    tone_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] table_q [NUM_STEPS];
    logic [DUR_W-1:0] cnt;
    logic [DUR_W-1:0] dur_lat;
    logic [IDX_W-1:0] load_idx;
    logic             last_step;
    logic             step_end;

    assign last_step = (bus.step_idx == IDX_W'(NUM_STEPS - 1));
    assign step_end  = (cnt == dur_lat - DUR_W'(1));
    assign load_idx  = (state == IDLE || last_step) ? '0 : bus.step_idx + IDX_W'(1);

    always_ff @(posedge inclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STEPS; i++) table_q[i] <= '0;
        end else if (bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // divisor/step_idx are updated on the edge entering LOAD so the LOAD cycle already shows the new step
    always_ff @(posedge inclk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            dur_lat         <= '0;
            bus.divisor     <= '0;
            bus.div_reset_n <= 1'b0;
            bus.step_idx    <= '0;
            bus.step_tick   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.step_tick <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state           <= LOAD;
                        dur_lat         <= (bus.step_dur == '0) ? DUR_W'(1) : bus.step_dur;
                        bus.step_idx    <= '0;
                        bus.divisor     <= table_q[load_idx];
                        bus.step_tick   <= 1'b1;
                        bus.busy        <= 1'b1;
                        bus.div_reset_n <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.stop) begin
                        state           <= IDLE;
                        bus.divisor     <= '0;
                        bus.div_reset_n <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.step_idx    <= '0;
                    end else begin
                        state           <= RUN;
                        cnt             <= '0;
                        // a rest step (divisor 0) keeps the divider held in reset
                        bus.div_reset_n <= (bus.divisor != '0);
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state           <= IDLE;
                        bus.divisor     <= '0;
                        bus.div_reset_n <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.step_idx    <= '0;
                    end else if (step_end) begin
                        if (!last_step || bus.loop_en) begin
                            state           <= LOAD;
                            bus.step_idx    <= load_idx;
                            bus.divisor     <= table_q[load_idx];
                            bus.step_tick   <= 1'b1;
                            bus.div_reset_n <= 1'b0;
                        end else begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.busy        <= 1'b0;
                            bus.div_reset_n <= 1'b0;
                            bus.divisor     <= '0;
                        end
                    end else begin
                        cnt <= cnt + DUR_W'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a 4-entry table; cycle c means the c-th cycle after the start-sampling edge.
module tb_tone_sequencer;
    logic inclk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 inclk = ~inclk;

    tone_sequencer_if #(.DIV_W(32), .DUR_W(32), .IDX_W(2)) bus ();

    tone_sequencer #(.NUM_STEPS(4), .DIV_W(32), .DUR_W(32), .IDX_W(2)) dut (
        .inclk (inclk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    task automatic write_table(input logic [3:0][31:0] tbl);
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 2'(i);
            bus.wr_data = tbl[i];
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (bus.divisor !== 32'd0) begin bad++; $display("FAIL reset divisor got %0d want 0", bus.divisor); end
        total++; if (bus.div_reset_n !== 1'b0) begin bad++; $display("FAIL reset div_reset_n got %0b want 0", bus.div_reset_n); end
        total++; if (bus.step_idx !== 2'd0) begin bad++; $display("FAIL reset step_idx got %0d want 0", bus.step_idx); end
        total++; if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL reset step_tick got %0b want 0", bus.step_tick); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy got %0b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done got %0b want 0", bus.done); end
    endtask

    task automatic test_start_stop_idle();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_stop_idle busy got %0b want 0", bus.busy); end
        total++; if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL start_stop_idle step_tick got %0b want 0", bus.step_tick); end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL start_stop_idle later busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_sequence(input string name, input logic [3:0][31:0] tbl, input int dur);
        int          per;
        int          s;
        int          p;
        logic [1:0]  e_idx;
        logic        e_tick;
        logic [31:0] e_div;
        logic        e_rn;
        logic        e_busy;
        logic        e_done;
        per = ((dur == 0) ? 1 : dur) + 1;
        write_table(tbl);
        bus.step_dur = 32'(dur);
        bus.loop_en  = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 4 * per + 2; c++) begin
            e_idx = 2'd0;
            if (c <= 4 * per) begin
                s      = (c - 1) / per;
                p      = (c - 1) % per;
                e_idx  = 2'(s);
                e_tick = (p == 0);
                e_div  = tbl[s];
                e_rn   = (p != 0) && (tbl[s] != 32'd0);
                e_busy = 1'b1;
                e_done = 1'b0;
            end else begin
                e_tick = 1'b0;
                e_div  = 32'd0;
                e_rn   = 1'b0;
                e_busy = 1'b0;
                e_done = (c == 4 * per + 1);
            end
            if (c <= 4 * per) begin
                total++; if (bus.step_idx !== e_idx) begin bad++; $display("FAIL %s c%0d step_idx got %0d want %0d", name, c, bus.step_idx, e_idx); end
            end
            total++; if (bus.step_tick !== e_tick) begin bad++; $display("FAIL %s c%0d step_tick got %0b want %0b", name, c, bus.step_tick, e_tick); end
            total++; if (bus.divisor !== e_div) begin bad++; $display("FAIL %s c%0d divisor got %0d want %0d", name, c, bus.divisor, e_div); end
            total++; if (bus.div_reset_n !== e_rn) begin bad++; $display("FAIL %s c%0d div_reset_n got %0b want %0b", name, c, bus.div_reset_n, e_rn); end
            total++; if (bus.busy !== e_busy) begin bad++; $display("FAIL %s c%0d busy got %0b want %0b", name, c, bus.busy, e_busy); end
            total++; if (bus.done !== e_done) begin bad++; $display("FAIL %s c%0d done got %0b want %0b", name, c, bus.done, e_done); end
            tick();
        end
    endtask

    task automatic test_loop_stop();
        write_table({32'd40, 32'd30, 32'd20, 32'd10});
        bus.step_dur = 32'd3;
        bus.loop_en  = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL loop c%0d done got %0b want 0", c, bus.done); end
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL loop c%0d busy got %0b want 1", c, bus.busy); end
            if (c == 17) begin
                total++; if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL loop wrap step_tick got %0b want 1", bus.step_tick); end
                total++; if (bus.step_idx !== 2'd0) begin bad++; $display("FAIL loop wrap step_idx got %0d want 0", bus.step_idx); end
                total++; if (bus.divisor !== 32'd10) begin bad++; $display("FAIL loop wrap divisor got %0d want 10", bus.divisor); end
            end
            if (c == 20) bus.stop = 1'b1;
            tick();
        end
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stop busy got %0b want 0", bus.busy); end
        total++; if (bus.div_reset_n !== 1'b0) begin bad++; $display("FAIL stop div_reset_n got %0b want 0", bus.div_reset_n); end
        total++; if (bus.divisor !== 32'd0) begin bad++; $display("FAIL stop divisor got %0d want 0", bus.divisor); end
        total++; if (bus.step_idx !== 2'd0) begin bad++; $display("FAIL stop step_idx got %0d want 0", bus.step_idx); end
        for (int c = 21; c <= 24; c++) begin
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL stop c%0d done got %0b want 0", c, bus.done); end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        write_table({32'd40, 32'd30, 32'd20, 32'd10});
        bus.step_dur = 32'd3;
        bus.loop_en  = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        total++; if (bus.step_idx !== 2'd1) begin bad++; $display("FAIL rst_mid c6 step_idx got %0d want 1", bus.step_idx); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got %0b want 0", bus.busy); end
        total++; if (bus.divisor !== 32'd0) begin bad++; $display("FAIL rst_mid divisor got %0d want 0", bus.divisor); end
        total++; if (bus.step_idx !== 2'd0) begin bad++; $display("FAIL rst_mid step_idx got %0d want 0", bus.step_idx); end
        total++; if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL rst_mid step_tick got %0b want 0", bus.step_tick); end
        total++; if (bus.div_reset_n !== 1'b0) begin bad++; $display("FAIL rst_mid div_reset_n got %0b want 0", bus.div_reset_n); end
        bus.step_dur = 32'd1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            total++; if (bus.divisor !== 32'd0) begin bad++; $display("FAIL cleared_table c%0d divisor got %0d want 0", c, bus.divisor); end
            total++; if (bus.div_reset_n !== 1'b0) begin bad++; $display("FAIL cleared_table c%0d div_reset_n got %0b want 0", c, bus.div_reset_n); end
            tick();
        end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL cleared_table c9 done got %0b want 1", bus.done); end
        tick();
        write_table({32'd8, 32'd7, 32'd6, 32'd5});
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.step_idx !== 2'd0) begin bad++; $display("FAIL replay c1 step_idx got %0d want 0", bus.step_idx); end
        total++; if (bus.divisor !== 32'd5) begin bad++; $display("FAIL replay c1 divisor got %0d want 5", bus.divisor); end
        tick();
        tick();
        total++; if (bus.step_idx !== 2'd1) begin bad++; $display("FAIL replay c3 step_idx got %0d want 1", bus.step_idx); end
        total++; if (bus.divisor !== 32'd6) begin bad++; $display("FAIL replay c3 divisor got %0d want 6", bus.divisor); end
        for (int c = 3; c < 11; c++) tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL replay end busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_write_during_run();
        write_table({32'd40, 32'd30, 32'd20, 32'd10});
        bus.step_dur = 32'd3;
        bus.loop_en  = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        total++; if (bus.divisor !== 32'd20) begin bad++; $display("FAIL wr_run c6 divisor got %0d want 20", bus.divisor); end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 32'd99;
        tick();
        bus.wr_en = 1'b0;
        total++; if (bus.divisor !== 32'd20) begin bad++; $display("FAIL wr_run c7 divisor got %0d want 20", bus.divisor); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.step_idx !== 2'd1) begin bad++; $display("FAIL ign_start c8 step_idx got %0d want 1", bus.step_idx); end
        total++; if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL ign_start c8 step_tick got %0b want 0", bus.step_tick); end
        total++; if (bus.divisor !== 32'd20) begin bad++; $display("FAIL ign_start c8 divisor got %0d want 20", bus.divisor); end
        for (int c = 8; c < 21; c++) tick();
        total++; if (bus.step_idx !== 2'd1) begin bad++; $display("FAIL wr_run c21 step_idx got %0d want 1", bus.step_idx); end
        total++; if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL wr_run c21 step_tick got %0b want 1", bus.step_tick); end
        total++; if (bus.divisor !== 32'd99) begin bad++; $display("FAIL wr_run c21 divisor got %0d want 99", bus.divisor); end
        bus.stop = 1'b1;
        tick();
        bus.stop    = 1'b0;
        bus.loop_en = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wr_run stop busy got %0b want 0", bus.busy); end
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.loop_en  = 1'b0;
        bus.step_dur = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        test_reset();
        test_start_stop_idle();
        test_sequence("basic", {32'd40, 32'd30, 32'd20, 32'd10}, 3);
        test_sequence("rest", {32'd40, 32'd30, 32'd0, 32'd10}, 3);
        test_sequence("zero_dur", {32'd40, 32'd30, 32'd20, 32'd10}, 0);
        test_loop_stop();
        test_reset_mid_run();
        test_write_during_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Sequences the shared clock divider through a programmable list of divisors, holding each divisor for a fixed number of clock cycles. It drives the divider's divisor and active-low enable/reset input, producing a stepped tone pattern with optional rests and looping. It sits between the control/switch logic and the divider instance. Start/stop and busy/done give a simple handshake to the upstream control.

Parameters:
NUM_STEPS, 8, number of table entries; must be a power of two, at least 2
DIV_W, 32, divisor width; matches the divider's divisor port
DUR_W, 32, width of the step duration count
IDX_W, $clog2(NUM_STEPS), width of table index

Ports:
inclk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  level, sampled each cycle; begins a sequence when IDLE
stop  input  1  level; aborts a running sequence
loop_en  input  1  when 1, the sequence wraps from the last step to step 0 instead of finishing
step_dur  input  DUR_W  RUN cycles per step; latched on accepted start
wr_en  input  1  table write strobe
wr_addr  input  IDX_W  table write address
wr_data  input  DIV_W  table write data; 0 denotes a rest step
divisor  output  DIV_W  divisor to the divider (registered)
div_reset_n  output  1  active-low reset to the divider; 0 holds the divider in reset
step_idx  output  IDX_W  index of the current step
step_tick  output  1  one-cycle pulse in each LOAD cycle
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset (reset=1 at an edge) drives these values from the next cycle:
  - state=IDLE; divisor=0; div_reset_n=0; step_idx=0; step_tick=0; busy=0; done=0.
  - Duration counter=0; latched duration=0; all table entries=0.
- Table:
  - NUM_STEPS x DIV_W registers, written on the edge where wr_en=1. Writes are allowed in any state.
  - divisor is captured only in LOAD. A write to the current step takes effect at that step's next LOAD.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - busy=0 and div_reset_n=0.
  - start=1 and stop=0 → LOAD. In the same transition, step_idx←0 and the latched duration←max(step_dur,1). A step_dur of 0 is treated as 1.
- LOAD (exactly 1 cycle):
  - divisor←table[step_idx]; step_tick=1; busy=1; div_reset_n=0. This forces a clean divider restart.
  - → RUN; duration counter←0.
- RUN:
  - busy=1.
  - div_reset_n=1 if divisor≠0, else 0. A rest step keeps the divider in reset for the whole step.
  - The counter increments each cycle.
  - At count == latched duration−1:
    - If step_idx < NUM_STEPS−1: step_idx+1 → LOAD.
    - Else if loop_en=1 (sampled that cycle): step_idx←0 → LOAD. The latched duration is kept.
    - Else → DONE.
- DONE (exactly 1 cycle): done=1, busy=0, div_reset_n=0, divisor←0 → IDLE.
- Step period is latched duration + 1 cycles (LOAD + RUN). Full non-loop sequence: start sampled at edge t0 → done high during cycle t0 + NUM_STEPS×(dur+1) + 1.
- stop=1 in LOAD or RUN:
  - Next state is IDLE. divisor←0, div_reset_n=0, busy=0.
  - No done pulse; step_idx←0.
  - stop has priority over step advance and wrap.
- Simultaneous events and ignored inputs:
  - start while busy or DONE is ignored.
  - start and stop together in IDLE: stop wins, remains IDLE.
  - Table write and LOAD reading the same address in the same cycle: LOAD sees the old value.
- Reset mid-operation: reset has priority over everything, including wr_en. All values return to their reset values at the next edge.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Basic sequence. NUM_STEPS=4, table={10,20,30,40}, step_dur=3, loop_en=0, pulse start at t0.
   → step_idx 0,1,2,3, each held 4 cycles; step_tick at t1,t5,t9,t13; divisor 10/20/30/40; div_reset_n low only in LOAD cycles.
   → done high only at t17; busy high t1–t16.
2. Rest step. Table={10,0,30,40}, step_dur=3 → during step 1, divisor=0 and div_reset_n=0 for all 4 cycles; other steps as in scenario 1.
3. Loop and stop.
   - Loop: loop_en=1 → after step 3 the sequencer returns to step 0 at t17 with step_tick; no done; busy stays 1.
   - Stop: assert stop at t20 → at t21 busy=0, div_reset_n=0, divisor=0, step_idx=0, and done never pulses.
4. Zero duration. step_dur=0 → behaves as 1: each step is 2 cycles; done at t0+4×2+1=t9.
5. Reset mid-RUN. Assert reset at t6 for 1 cycle → at t7 all outputs are at reset values and the table reads all zeros.
   → A following start with a fresh table replays from step_idx=0.
6. Write during run.
   - Looping sequence: write table[1]=99 while step 1 is in RUN → divisor stays 20 until step 1's next LOAD, then becomes 99.
   - start pulsed mid-run → ignored (no restart, step_idx undisturbed).
